// File: rtl/transmit.sv
// -----------------------------------------------------------------------------
// transmit -- single-wire byte-link serial transmitter.
//
// Takes a byte through a valid/ready handshake into a one-entry holding
// buffer, then shifts it out on txd MSB first inside a frame of
//   START(0) | D7..D0 | END(0) | GAP(1) x IDLE_BITS
// with every bit lasting CLKS_PER_BIT clk cycles. The buffer is freed as soon
// as a frame starts, so a producer can queue the next byte while the current
// one is on the line.
//
// Ports
//   clk             system clock, all state changes on posedge
//   rst             asynchronous active-low reset
//   word[7:0]       byte to send, sampled on the accept edge
//   send            producer valid; accepted when send & transmit_ready
//   transmit_ready  1 = holding buffer empty
//   txd             serial line, idles high
//   busy            1 while a frame (including its gap) is in progress
// -----------------------------------------------------------------------------
module transmit #(
    parameter int CLKS_PER_BIT = 1,
    parameter int IDLE_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] word,
    input  logic       send,
    output logic       transmit_ready,
    output logic       txd,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int GW = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_END,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    buf_q, buf_d;
    logic [7:0]    shift_q, shift_d;
    logic          ready_q, ready_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          bit_done;

    // Last clk of the current bit period.
    assign bit_done = (clk_cnt_q == CLK_LAST);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        buf_d     = buf_q;
        shift_d   = shift_q;
        ready_d   = ready_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;

        // Accept only into an empty buffer; a full buffer is never overwritten.
        if (send && ready_q) begin
            buf_d   = word;
            ready_d = 1'b0;
        end

        // Bit-period timer runs in every state that is driving a frame bit.
        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_done ? '0 : clk_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // Buffer full: start the frame and free the buffer on this edge.
                if (!ready_q) begin
                    shift_d   = buf_q;
                    ready_d   = 1'b1;
                    busy_d    = 1'b1;
                    txd_d     = 1'b0;
                    clk_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    txd_d     = shift_q[7];
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == 3'd7) begin
                        txd_d   = 1'b0;
                        state_d = S_END;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        txd_d     = shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                    end
                end
            end
            S_END: begin
                if (bit_done) begin
                    txd_d = 1'b1;
                    if (IDLE_BITS == 0) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (bit_done) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        busy_d  = 1'b0;
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            // NOTE: the data registers are reset as well; they are only a few
            // bits and this keeps unknowns from ever reaching txd.
            buf_q     <= '0;
            shift_q   <= '0;
            ready_q   <= 1'b1;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            buf_q     <= buf_d;
            shift_q   <= shift_d;
            ready_q   <= ready_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign transmit_ready = ready_q;
    assign txd            = txd_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_transmit.sv
// -----------------------------------------------------------------------------
// tb_transmit -- self-checking bench for transmit.
//
// Two instances share clk and rst: dut0 (CLKS_PER_BIT=1, IDLE_BITS=1) and
// dut1 (CLKS_PER_BIT=4, IDLE_BITS=2). A frame-schedule model predicts txd,
// busy and transmit_ready every cycle: each accepted byte gets a start edge
// max(accept+1, previous start + frame length + 1), and the line value is
// looked up from that frame's bit list. A small line decoder on dut0 also
// recovers the bytes from txd and compares them with what was accepted.
// -----------------------------------------------------------------------------
module tb_transmit;

    localparam int C0 = 1, I0 = 1;
    localparam int C1 = 4, I1 = 2;
    localparam int L0 = (10 + I0) * C0;
    localparam int L1 = (10 + I1) * C1;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [7:0] word0 = 8'h00;
    logic [7:0] word1 = 8'h00;
    logic       send0 = 1'b0;
    logic       send1 = 1'b0;
    logic [1:0] rdy;
    logic [1:0] txd;
    logic [1:0] busy;

    transmit #(.CLKS_PER_BIT(C0), .IDLE_BITS(I0)) u_dut0 (
        .clk            (clk),
        .rst            (rst),
        .word           (word0),
        .send           (send0),
        .transmit_ready (rdy[0]),
        .txd            (txd[0]),
        .busy           (busy[0])
    );

    transmit #(.CLKS_PER_BIT(C1), .IDLE_BITS(I1)) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .word           (word1),
        .send           (send1),
        .transmit_ready (rdy[1]),
        .txd            (txd[1]),
        .busy           (busy[1])
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, per instance.
    int         clks [2] = '{C0, C1};
    int         lens [2] = '{L0, L1};
    int         edge_n   = 0;
    int         nf   [2];           // earliest start edge for the next frame
    int         cs   [2];           // start edge of the current frame
    logic [7:0] cw   [2];
    bit         cv   [2];
    int         ps   [2];           // start edge of the queued frame
    logic [7:0] pw   [2];
    bit         pv   [2];
    bit         m_rdy[2];
    bit         acc  [2];

    // Line decoder for dut0.
    int         rx_st = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_exp[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            nf[d]    = 0;
            cv[d]    = 1'b0;
            pv[d]    = 1'b0;
            m_rdy[d] = 1'b1;
            acc[d]   = 1'b0;
        end
        rx_st = 0;
        rx_exp.delete();
    endtask

    // Line value of the frame schedule after the current edge.
    function automatic logic exp_txd(input int d);
        int k;
        if (!cv[d] || edge_n < cs[d] || edge_n >= cs[d] + lens[d]) return 1'b1;
        k = (edge_n - cs[d]) / clks[d];
        if (k == 0 || k == 9) return 1'b0;
        if (k <= 8) return cw[d][8-k];
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int d);
        return cv[d] && edge_n >= cs[d] && edge_n < cs[d] + lens[d];
    endfunction

    task automatic rx_decode();
        logic [7:0] want;
        if (rx_st == 0) begin
            if (txd[0] == 1'b0) rx_st = 1;
        end else if (rx_st <= 8) begin
            rx_sh = {rx_sh[6:0], txd[0]};
            rx_st++;
        end else begin
            check("rx_end_bit", 32'(txd[0]), 32'd0);
            want = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'hxx;
            check("rx_word", 32'(rx_sh), 32'(want));
            rx_st = 0;
        end
    endtask

    // One clk: drive inputs, take the edge, advance the model, compare.
    task automatic step(input logic s0, input logic [7:0] w0,
                        input logic s1, input logic [7:0] w1);
        logic       s [2];
        logic [7:0] w [2];
        send0 = s0; word0 = w0;
        send1 = s1; word1 = w1;
        s[0] = s0; s[1] = s1;
        w[0] = w0; w[1] = w1;
        @(posedge clk);
        edge_n++;
        if (!rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (pv[d] && ps[d] <= edge_n) begin
                    cv[d] = 1'b1;
                    cs[d] = ps[d];
                    cw[d] = pw[d];
                    pv[d] = 1'b0;
                end
                acc[d] = s[d] && m_rdy[d];
                if (acc[d]) begin
                    ps[d] = (edge_n + 1 > nf[d]) ? edge_n + 1 : nf[d];
                    pw[d] = w[d];
                    pv[d] = 1'b1;
                    nf[d] = ps[d] + lens[d] + 1;
                    if (d == 0) rx_exp.push_back(w[d]);
                end
                m_rdy[d] = !pv[d];
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("txd%0d@%0d", d, edge_n),  32'(txd[d]),  32'(exp_txd(d)));
            check($sformatf("busy%0d@%0d", d, edge_n), 32'(busy[d]), 32'(exp_busy(d)));
            check($sformatf("rdy%0d@%0d", d, edge_n),  32'(rdy[d]),  32'(m_rdy[d]));
        end
        if (rst) rx_decode();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // Hold send on dut0 with byte b until the model accepts it.
    task automatic send_dut0(input logic [7:0] b);
        int guard = 0;
        do begin
            step(1'b1, b, 1'b0, 8'h00);
            guard++;
        end while (!acc[0] && guard < 100);
        check($sformatf("accept0_%02h", b), 32'(acc[0]), 32'd1);
    endtask

    initial begin
        model_reset();

        // Reset held across edges, then released away from the edge.
        idle(2);
        rst = 1'b1;
        idle(2);

        // Single byte: 0,1,0,1,0,0,1,0,1,0,1 on dut0.
        send_dut0(8'hA5);
        idle(14);

        // Back-to-back: second byte queued while the first is in DATA.
        send_dut0(8'h3C);
        idle(3);
        send_dut0(8'hFF);
        idle(30);

        // Buffer full: 56 is held on the input until the buffer frees.
        send_dut0(8'h12);
        send_dut0(8'h34);
        send_dut0(8'h56);
        idle(40);

        // Loopback through the line decoder.
        send_dut0(8'h00);
        send_dut0(8'h81);
        send_dut0(8'hFE);
        idle(40);
        check("rx_drain_directed", 32'(rx_exp.size()), 32'd0);

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0), 8'($urandom),
                 ($urandom_range(0, 3) == 0), 8'($urandom));
        end
        idle(80);
        check("rx_drain_random", 32'(rx_exp.size()), 32'd0);

        // dut1: 0x80 with 4 clk per bit, reset asserted during data bit 3.
        begin
            int guard = 0;
            do begin
                step(1'b0, 8'h00, 1'b1, 8'h80);
                guard++;
            end while (!acc[1] && guard < 100);
            check("accept1_80", 32'(acc[1]), 32'd1);
        end
        idle(18);
        rst = 1'b0;
        #2;
        model_reset();
        check("arst_txd1",  32'(txd[1]),  32'd1);
        check("arst_busy1", 32'(busy[1]), 32'd0);
        check("arst_rdy1",  32'(rdy[1]),  32'd1);
        check("arst_txd0",  32'(txd[0]),  32'd1);
        idle(3);
        rst = 1'b1;
        idle(20);

        // First posedge after release may accept.
        send_dut0(8'h5A);
        idle(20);
        check("rx_drain_final", 32'(rx_exp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/transmit.md
Name: transmit

Overview:
- Serial transmitter for the team's single-wire byte link; the other end of the existing receiver.
- Accepts a parallel byte through a valid/ready handshake and holds it in a one-entry buffer.
- Shifts the byte onto txd, MSB first, framed exactly as the receiver expects.
- Sits between a byte producer (test logic, FSM, FIFO) and the serial line.

Parameters:
- CLKS_PER_BIT, 1, clk cycles per serial bit period; minimum 1. Default 1 matches the receiver, which samples once per clk.
- IDLE_BITS, 1, minimum number of high bit periods driven between frames; minimum 0.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset; 0 resets immediately, independent of clk.
- word  input  8  byte to send; sampled on the accept edge.
- send  input  1  producer valid; a byte is accepted on a posedge where send=1 and transmit_ready=1.
- transmit_ready  output  1  1 = holding buffer empty, can accept a byte.
- txd  output  1  serial line; idle level 1.
- busy  output  1  1 while a frame, including its idle gap, is in progress.

Behaviour:
- Reset (rst=0, async): txd=1, transmit_ready=1, busy=0; holding buffer empty; state IDLE; all counters 0. Any frame in progress is aborted, with txd forced high immediately.
- Frame, one bit period each, in order:
  - START: txd=0.
  - DATA: word[7] down to word[0].
  - END: txd=0. The receiver latches on a 0 after 8 data bits.
  - GAP: txd=1 for IDLE_BITS periods.
- Frame length is (10+IDLE_BITS)*CLKS_PER_BIT clk cycles.
- All outputs are registered; txd is driven from a flop, with no combinational path from inputs.
- Handshake and holding buffer:
  - Accept edge: send=1 and transmit_ready=1. word is stored in the buffer and transmit_ready goes 0 after that edge.
  - send while transmit_ready=0 is ignored; the buffer is never overwritten. word is don't-care when not accepted.
- State machine IDLE -> START -> DATA -> END -> GAP -> IDLE:
  - IDLE, buffer full: on the next edge, load the buffer into the shift register, set the buffer empty (transmit_ready=1), set busy=1, set txd=0, and enter START. Start-bit latency from the accept edge is therefore exactly 1 clk.
  - A clk_cnt of 0..CLKS_PER_BIT-1 times each bit period. The state or bit advances when clk_cnt=CLKS_PER_BIT-1.
  - DATA: a bit_cnt of 0..7 runs; the shift register shifts left and txd takes the MSB. After bit_cnt=7 completes, go to END.
  - END -> GAP. If IDLE_BITS=0, END goes directly to the IDLE-load decision instead.
  - GAP: gap_cnt counts bit periods. After IDLE_BITS periods, go to IDLE with busy=0 and txd=1.
  - If the buffer is full at the end of GAP, the next frame's START begins on the very next edge. IDLE lasts 1 clk minimum, with busy=0 for that cycle.
- Because the buffer is freed when the frame starts, a second byte may be accepted during a frame. This gives continuous back-to-back frames with no bubble beyond the IDLE-load cycle.
- Simultaneous accept and load on the same edge cannot occur: load requires a full buffer and accept requires an empty one.
- Counter widths: clk_cnt is $clog2(CLKS_PER_BIT)+1 bits; gap_cnt covers IDLE_BITS; bit_cnt is 3 bits. No wrap-around beyond the specified terminal counts.
- Reset mid-frame: output returns to idle level. No partial byte is retransmitted after reset release. The first accept after release is allowed on the first posedge with rst=1.

Test Plan:
- Reset: assert rst=0 mid-operation -> txd=1, transmit_ready=1, busy=0 asynchronously, before the next clk edge.
- Single byte, CLKS_PER_BIT=1, IDLE_BITS=1: send word=8'hA5 for 1 cycle -> txd sequence, one value per clk starting 1 clk after accept, is 0,1,0,1,0,0,1,0,1,0,1. busy is high for 11 cycles and transmit_ready is back to 1 after the start-bit edge.
- Back-to-back: accept 8'h3C, then 8'hFF while the first frame is in DATA -> frames are contiguous, with the second START on the edge after the first GAP ends plus 1 IDLE clk. The second frame's data is 1,1,1,1,1,1,1,1 followed by END=0.
- Buffer full: accept 8'h12, accept 8'h34, then hold send=1 with word=8'h56 while transmit_ready=0 -> only 12 and 34 appear on txd; 56 is sent only after transmit_ready returns to 1.
- Loopback: connect txd to the receiver's rxd (same clk, CLKS_PER_BIT=1), send 8'h00, 8'h81, 8'hFE -> the receiver word matches each byte, with its ready pulsing once per frame.
- CLKS_PER_BIT=4: send 8'h80 -> each bit is held 4 clk: start 0x4, 1x4, 0x28, end 0x4, gap 1x4. Reset asserted during bit 3 aborts the frame and txd=1 holds thereafter.
